// File: rtl/store_byte_serializer_if.sv
// Store request and byte-beat bus between the MEM-stage store path and a
// byte-wide data-memory write port.
interface store_byte_serializer_if #(
  parameter int DATA_W = 64,
  parameter int LANE_W = 8,
  parameter int ADDR_W = 64
);
  // Request side
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] in_addr;
  logic [1:0]        in_size;
  // Beat side
  logic              out_valid;
  logic              out_ready;
  logic [LANE_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  // Status
  logic              busy;

  // The store-path / memory-port side
  modport master (
    output in_valid, in_data, in_addr, in_size, out_ready,
    input  in_ready, out_valid, out_data, out_addr, out_last, busy
  );

  // The serializer
  modport slave (
    input  in_valid, in_data, in_addr, in_size, out_ready,
    output in_ready, out_valid, out_data, out_addr, out_last, busy
  );
endinterface

// File: rtl/store_byte_serializer.sv
// Store byte serializer: accepts a register value plus access size and emits
// the low 1/2/4/8 bytes one per beat, little-endian, at ascending addresses.
// Bytes above the access size are never emitted (truncation).
// DATA_W must be a multiple of LANE_W.
module store_byte_serializer #(
  parameter int DATA_W = 64,
  parameter int LANE_W = 8,
  parameter int ADDR_W = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  store_byte_serializer_if.slave  bus
);

  localparam int unsigned NBEATS = DATA_W / LANE_W;
  localparam int          IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [ADDR_W-1:0] base_q,  base_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic [IDX_W-1:0]  last_q,  last_d;
  logic              in_send;
  logic              is_last;

  // Index of the final beat for a given size code (beats = 1 << size),
  // clamped to the number of lanes the data word actually holds.
  function automatic logic [IDX_W-1:0] last_index(input logic [1:0] size);
    int unsigned n;
    n = 32'd1 << size;
    if (n > NBEATS) n = NBEATS;
    return IDX_W'(n - 1);
  endfunction

  assign in_send = (state_q == SEND);
  assign is_last = (idx_q == last_q);

  // Next-state logic: latch a request in IDLE, shift out one lane per accepted beat in SEND
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    base_d  = base_q;
    idx_d   = idx_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          shreg_d = bus.in_data;
          base_d  = bus.in_addr;
          idx_d   = '0;
          last_d  = last_index(bus.in_size);
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.out_ready) begin
          shreg_d = shreg_q >> LANE_W;
          idx_d   = idx_q + IDX_W'(1);
          // Always pass through IDLE after the last beat, so no same-cycle re-accept
          if (is_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      base_q  <= '0;
      idx_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  // Outputs are pure functions of the registers, so they hold steady during a stall.
  // Beat fields are forced to zero outside SEND; the address adder wraps modulo 2^ADDR_W.
  assign bus.in_ready  = !in_send;
  assign bus.out_valid = in_send;
  assign bus.busy      = in_send;
  assign bus.out_data  = in_send ? shreg_q[LANE_W-1:0] : '0;
  assign bus.out_addr  = in_send ? (base_q + ADDR_W'(idx_q)) : '0;
  assign bus.out_last  = in_send && is_last;

endmodule

// File: tb/tb_store_byte_serializer.sv
// Self-checking bench for store_byte_serializer: a queue-based reference
// model of expected beats, directed scenarios and randomized requests.
module tb_store_byte_serializer;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  store_byte_serializer_if #(.DATA_W(64), .LANE_W(8), .ADDR_W(64)) bus ();

  store_byte_serializer #(.DATA_W(64), .LANE_W(8), .ADDR_W(64)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic [63:0] addr;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    beats_done = 0;
  int    rdy_mode = 0;      // 0: always ready, 1: random, 2: forced by rdy_force
  logic  rdy_force = 1'b1;

  localparam logic [63:0] D = 64'h1122334455667788;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Memory-port ready pattern, updated just after each rising edge
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = rdy_force;
    endcase
  end

  // Reference model and monitor: a request is a list of bytes data[8i+:8]
  // at addr+i for i < 2**size; the model is idle exactly when that list is empty.
  always @(negedge clk) begin : monitor
    bit    idle;
    int    n;
    beat_t b;
    if (!reset_n) begin
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_last",  bus.out_last,  0);
      check("rst_busy",      bus.busy,      0);
      check("rst_out_data",  bus.out_data,  0);
      check("rst_out_addr",  bus.out_addr,  0);
      exp_q.delete();
    end else begin
      idle = (exp_q.size() == 0);
      check("in_ready",  bus.in_ready,  idle);
      check("out_valid", bus.out_valid, !idle);
      check("busy",      bus.busy,      !idle);
      check("last_gate", bus.out_last & ~bus.out_valid, 0);
      if (!idle && bus.out_valid) begin
        check("beat_data", bus.out_data, exp_q[0].data);
        check("beat_addr", bus.out_addr, exp_q[0].addr);
        check("beat_last", bus.out_last, exp_q[0].last);
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          beats_done++;
        end
      end
      if (idle && bus.in_valid) begin
        n = 1 << bus.in_size;
        for (int i = 0; i < n; i++) begin
          b.data = 8'((bus.in_data >> (8 * i)) & 64'hFF);
          b.addr = bus.in_addr + 64'(i);
          b.last = (i == n - 1);
          exp_q.push_back(b);
        end
      end
    end
  end

  // Present a request and hold it until accepted; call just after a rising edge
  task automatic send_req(input logic [63:0] d, input logic [63:0] a, input logic [1:0] s);
    bit ok;
    ok = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_addr  = a;
    bus.in_size  = s;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = {$urandom, $urandom};
    bus.in_size  = 2'($urandom_range(0, 3));
    check("accept_in_time", ok, 1);
  endtask

  // Wait until the model has drained and the DUT reports not busy
  task automatic wait_idle();
    bit done;
    done = 0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !bus.busy) begin
        done = 1;
        break;
      end
    end
    check("drain_in_time", done, 1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_addr   = '0;
    bus.in_size   = 2'b00;
    bus.out_ready = 1'b1;

    // Reset state
    #1 reset_n = 1'b0;
    #2;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_busy",      bus.busy,      0);
    check("reset_out_last",  bus.out_last,  0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("reset_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // 1: single byte
    send_req(D, 64'h100, 2'b00);
    wait_idle();

    // 2: full double
    send_req(D, 64'h100, 2'b11);
    wait_idle();

    // 3: half with a stalled memory port; first beat must hold still
    rdy_mode  = 2;
    rdy_force = 1'b0;
    @(posedge clk);
    #1;
    send_req(D, 64'h100, 2'b01);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_hold_valid", bus.out_valid, 1);
      check("t3_hold_data",  bus.out_data,  64'h88);
      check("t3_hold_addr",  bus.out_addr,  64'h100);
      check("t3_hold_last",  bus.out_last,  0);
    end
    rdy_force = 1'b1;
    wait_idle();
    rdy_mode = 0;

    // 4: word crossing the top of the address space
    send_req(D, 64'hFFFF_FFFF_FFFF_FFFE, 2'b10);
    wait_idle();

    // 5: reset two beats into a double, then a fresh byte store
    begin
      int start;
      bit reached;
      start   = beats_done;
      reached = 0;
      send_req(D, 64'h200, 2'b11);
      for (int n = 0; n < 50; n++) begin
        @(posedge clk);
        #2;
        if (beats_done - start >= 2) begin
          reached = 1;
          break;
        end
      end
      check("t5_two_beats", reached, 1);
      reset_n = 1'b0;
      #1;
      check("t5_valid_after_rst", bus.out_valid, 0);
      check("t5_last_after_rst",  bus.out_last,  0);
      check("t5_busy_after_rst",  bus.busy,      0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      send_req(64'hAABB_CCDD_EEFF_0042, 64'h300, 2'b00);
      wait_idle();
    end

    // 6: second request held while a double is in flight
    send_req(D, 64'h400, 2'b11);
    send_req(64'h0123_4567_89AB_CDEF, 64'h500, 2'b01);
    wait_idle();

    // Randomized requests, back-to-back or with gaps, random memory-port stalls
    for (int t = 0; t < 40; t++) begin
      logic [63:0] a;
      rdy_mode = $urandom_range(0, 1);
      a = ($urandom_range(0, 3) == 0) ? (64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7)))
                                      : {$urandom, $urandom};
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send_req({$urandom, $urandom}, a, 2'($urandom_range(0, 3)));
    end
    rdy_mode = 0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
